// File: rtl/embark_ifetch.sv
// embark_ifetch: instruction fetch front end with a credit-limited request
// stream, a fixed-latency in-flight tracker and a prefetch FIFO to decode.
//
// Decode handshake: inst_valid means the FIFO head (inst_data/inst_pc) is
// presented. An instruction is consumed on a rising clock edge where
// inst_valid and inst_ready are both 1. While inst_ready is 0, the head
// stays stable until it is accepted or a redirect flushes it. inst_valid
// never depends on inst_ready.
module embark_ifetch #(
  parameter int                   MEM_DEPTH     = 16,
  parameter logic [MEM_DEPTH-1:0] PC_START_ADDR = '0,
  parameter int                   FIFO_DEPTH    = 4,
  parameter int                   MEM_LATENCY   = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic                 imem_req,
  output logic [MEM_DEPTH-1:0] imem_addr,
  input  logic [31:0]          imem_rdata,
  input  logic                 redirect_valid,
  input  logic [MEM_DEPTH-1:0] redirect_pc,
  output logic                 inst_valid,
  input  logic                 inst_ready,
  output logic [31:0]          inst_data,
  output logic [MEM_DEPTH-1:0] inst_pc
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + MEM_LATENCY + 1) + 1;
  localparam logic [MEM_DEPTH-1:0] PC_STEP   = MEM_DEPTH'(4);
  localparam logic [CNT_W-1:0]     FIFO_CAP  = CNT_W'(FIFO_DEPTH);

  // Fetch PC
  logic [MEM_DEPTH-1:0] pc_q, pc_d;

  // In-flight shift pipeline: stage i holds a request issued i+1 cycles ago
  logic [MEM_LATENCY-1:0] inf_valid_q, inf_valid_d;
  logic [MEM_DEPTH-1:0]   inf_pc_q [MEM_LATENCY];
  logic [MEM_DEPTH-1:0]   inf_pc_d [MEM_LATENCY];

  // Prefetch FIFO storage and pointers
  logic [31:0]          fifo_data_q [FIFO_DEPTH];
  logic [31:0]          fifo_data_d [FIFO_DEPTH];
  logic [MEM_DEPTH-1:0] fifo_pc_q   [FIFO_DEPTH];
  logic [MEM_DEPTH-1:0] fifo_pc_d   [FIFO_DEPTH];
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;

  // Derived control
  logic [CNT_W-1:0] inflight_cnt;
  logic [CNT_W-1:0] credit_used;
  logic             req_int;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             pop;

  // Count valid in-flight stages from registered state only
  always_comb begin
    inflight_cnt = '0;
    for (int i = 0; i < MEM_LATENCY; i++) begin
      inflight_cnt = inflight_cnt + CNT_W'(inf_valid_q[i]);
    end
  end

  // Credit check, FIFO status and handshake strobes
  always_comb begin
    credit_used = count_q + inflight_cnt;
    req_int     = !redirect_valid && (credit_used < FIFO_CAP);
    fifo_empty  = (count_q == '0);
    fifo_full   = (count_q == FIFO_CAP);
    pop         = !fifo_empty && inst_ready;
    // A response whose request is being squashed this cycle is dropped
    push        = inf_valid_q[MEM_LATENCY-1] && !redirect_valid;
  end

  // Outputs: forced to reset values while reset is held
  always_comb begin
    imem_req   = req_int && !reset;
    imem_addr  = reset ? PC_START_ADDR : pc_q;
    inst_valid = !fifo_empty && !reset;
    inst_data  = inst_valid ? fifo_data_q[rd_ptr_q] : '0;
    inst_pc    = inst_valid ? fifo_pc_q[rd_ptr_q] : '0;
  end

  // Next fetch PC: redirect wins, otherwise advance on each issued request
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (req_int) begin
      pc_d = pc_q + PC_STEP;
    end
  end

  // In-flight pipeline shift; a redirect invalidates every stage
  always_comb begin
    inf_valid_d    = '0;
    inf_pc_d       = inf_pc_q;
    inf_valid_d[0] = req_int;
    inf_pc_d[0]    = pc_q;
    for (int i = 1; i < MEM_LATENCY; i++) begin
      inf_valid_d[i] = inf_valid_q[i-1];
      inf_pc_d[i]    = inf_pc_q[i-1];
    end
    if (redirect_valid) begin
      inf_valid_d = '0;
    end
  end

  // FIFO write/read/count; flush after the head handshake on redirect
  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_pc_d   = fifo_pc_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    if (push) begin
      fifo_data_d[wr_ptr_q] = imem_rdata;
      fifo_pc_d[wr_ptr_q]   = inf_pc_q[MEM_LATENCY-1];
      wr_ptr_d              = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (redirect_valid) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q        <= PC_START_ADDR;
      inf_valid_q <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      for (int i = 0; i < MEM_LATENCY; i++) begin
        inf_pc_q[i] <= '0;
      end
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_pc_q[i]   <= '0;
      end
    end else begin
      pc_q        <= pc_d;
      inf_valid_q <= inf_valid_d;
      inf_pc_q    <= inf_pc_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      fifo_data_q <= fifo_data_d;
      fifo_pc_q   <= fifo_pc_d;
    end
  end

  // The credit scheme must make a push into a full FIFO impossible
  fifo_no_overflow: assert property (
    @(posedge clock) disable iff (reset) !(push && fifo_full && !pop)
  );

endmodule

// File: tb/tb_embark_ifetch.sv
// tb_embark_ifetch: vector table and reference scoreboard for embark_ifetch.
module tb_embark_ifetch;

  logic clock;
  int   n_cmp = 0;
  int   n_err = 0;

  // Clock/reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ROM: word at byte address a is a>>2
  function automatic logic [31:0] rom(input logic [15:0] a);
    return {18'h0, a[15:2]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Main DUT: defaults (latency 1, depth 4, start 0)
  logic        m_rst = 1'b1, m_rv = 1'b0, m_rdy = 1'b1;
  logic [15:0] m_rpc = '0;
  logic        m_req, m_valid;
  logic [15:0] m_addr, m_pc;
  logic [31:0] m_rdata, m_data;
  logic [15:0] m_mem_a;

  embark_ifetch u_dut (
    .clock(clock), .reset(m_rst), .imem_req(m_req), .imem_addr(m_addr),
    .imem_rdata(m_rdata), .redirect_valid(m_rv), .redirect_pc(m_rpc),
    .inst_valid(m_valid), .inst_ready(m_rdy), .inst_data(m_data), .inst_pc(m_pc)
  );
  always @(posedge clock) m_mem_a <= m_addr;
  assign m_rdata = rom(m_mem_a);

  // Latency-3 DUT
  logic        t_rst = 1'b1, t_rv = 1'b0, t_rdy = 1'b0;
  logic [15:0] t_rpc = '0;
  logic        t_req, t_valid;
  logic [15:0] t_addr, t_pc;
  logic [31:0] t_rdata, t_data;
  logic [15:0] t_mem_a [3];

  embark_ifetch #(.MEM_LATENCY(3), .FIFO_DEPTH(4)) u_dut_l3 (
    .clock(clock), .reset(t_rst), .imem_req(t_req), .imem_addr(t_addr),
    .imem_rdata(t_rdata), .redirect_valid(t_rv), .redirect_pc(t_rpc),
    .inst_valid(t_valid), .inst_ready(t_rdy), .inst_data(t_data), .inst_pc(t_pc)
  );
  always @(posedge clock) begin
    t_mem_a[0] <= t_addr;
    t_mem_a[1] <= t_mem_a[0];
    t_mem_a[2] <= t_mem_a[1];
  end
  assign t_rdata = rom(t_mem_a[2]);

  // Wrapping-start DUT
  logic        w_rst = 1'b1, w_rv = 1'b0, w_rdy = 1'b1;
  logic [15:0] w_rpc = '0;
  logic        w_req, w_valid;
  logic [15:0] w_addr, w_pc;
  logic [31:0] w_rdata, w_data;
  logic [15:0] w_mem_a;

  embark_ifetch #(.PC_START_ADDR(16'hFFF8)) u_dut_wrap (
    .clock(clock), .reset(w_rst), .imem_req(w_req), .imem_addr(w_addr),
    .imem_rdata(w_rdata), .redirect_valid(w_rv), .redirect_pc(w_rpc),
    .inst_valid(w_valid), .inst_ready(w_rdy), .inst_data(w_data), .inst_pc(w_pc)
  );
  always @(posedge clock) w_mem_a <= w_addr;
  assign w_rdata = rom(w_mem_a);

  // Vector table for the main DUT, one record per cycle
  typedef struct {
    logic        rst;
    logic        rv;
    logic [15:0] rpc;
    logic        rdy;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_valid;
    logic [15:0] e_pc;
    logic [31:0] e_data;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input logic rst, input logic rv, input logic [15:0] rpc,
                         input logic rdy, input logic e_req, input logic [15:0] e_addr,
                         input logic e_valid, input logic [15:0] e_pc, input logic [31:0] e_data);
    vec_t v;
    v.rst = rst; v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.e_req = e_req;
    v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc; v.e_data = e_data;
    vq.push_back(v);
  endtask

  // Scoreboard queue: {pc, data}
  logic [47:0] exp_q[$];

  initial begin
    logic [47:0] e;
    logic [15:0] mpc, ppc;
    logic        pv, ereq, ev;
    int          nreq;

    //       rst rv rpc      rdy req addr     val pc       data
    add_vec(1, 0, 16'h0,   1,  0, 16'h0000, 0, 16'h0000, 32'h00);
    add_vec(1, 0, 16'h0,   1,  0, 16'h0000, 0, 16'h0000, 32'h00);
    add_vec(0, 0, 16'h0,   1,  1, 16'h0000, 0, 16'h0000, 32'h00);
    add_vec(0, 0, 16'h0,   1,  1, 16'h0004, 0, 16'h0000, 32'h00);
    add_vec(0, 0, 16'h0,   1,  1, 16'h0008, 1, 16'h0000, 32'h00);
    add_vec(0, 0, 16'h0,   1,  1, 16'h000C, 1, 16'h0004, 32'h01);
    add_vec(0, 0, 16'h0,   0,  1, 16'h0010, 1, 16'h0008, 32'h02);
    add_vec(0, 0, 16'h0,   0,  1, 16'h0014, 1, 16'h0008, 32'h02);
    add_vec(0, 0, 16'h0,   0,  0, 16'h0018, 1, 16'h0008, 32'h02);
    add_vec(0, 0, 16'h0,   0,  0, 16'h0018, 1, 16'h0008, 32'h02);
    add_vec(0, 0, 16'h0,   1,  0, 16'h0018, 1, 16'h0008, 32'h02);
    add_vec(0, 0, 16'h0,   1,  1, 16'h0018, 1, 16'h000C, 32'h03);
    add_vec(0, 0, 16'h0,   1,  1, 16'h001C, 1, 16'h0010, 32'h04);
    add_vec(0, 0, 16'h0,   1,  1, 16'h0020, 1, 16'h0014, 32'h05);
    add_vec(0, 0, 16'h0,   1,  1, 16'h0024, 1, 16'h0018, 32'h06);
    add_vec(0, 0, 16'h0,   1,  1, 16'h0028, 1, 16'h001C, 32'h07);
    add_vec(0, 1, 16'h0100, 1, 0, 16'h002C, 1, 16'h0020, 32'h08);
    add_vec(0, 0, 16'h0,   1,  1, 16'h0100, 0, 16'h0000, 32'h00);
    add_vec(0, 0, 16'h0,   1,  1, 16'h0104, 0, 16'h0000, 32'h00);
    add_vec(0, 0, 16'h0,   1,  1, 16'h0108, 1, 16'h0100, 32'h40);
    add_vec(0, 0, 16'h0,   1,  1, 16'h010C, 1, 16'h0104, 32'h41);
    add_vec(0, 1, 16'h0300, 0, 0, 16'h0110, 1, 16'h0108, 32'h42);
    add_vec(0, 1, 16'h0200, 0, 0, 16'h0300, 0, 16'h0000, 32'h00);
    add_vec(0, 0, 16'h0,   1,  1, 16'h0200, 0, 16'h0000, 32'h00);
    add_vec(0, 0, 16'h0,   1,  1, 16'h0204, 0, 16'h0000, 32'h00);
    add_vec(0, 0, 16'h0,   1,  1, 16'h0208, 1, 16'h0200, 32'h80);
    add_vec(1, 0, 16'h0,   1,  0, 16'h0000, 0, 16'h0000, 32'h00);
    add_vec(0, 0, 16'h0,   1,  1, 16'h0000, 0, 16'h0000, 32'h00);
    add_vec(0, 0, 16'h0,   1,  1, 16'h0004, 0, 16'h0000, 32'h00);
    add_vec(0, 0, 16'h0,   1,  1, 16'h0008, 1, 16'h0000, 32'h00);

    // Table phase
    for (int i = 0; i < vq.size(); i++) begin
      @(posedge clock); #1;
      m_rst = vq[i].rst; m_rv = vq[i].rv; m_rpc = vq[i].rpc; m_rdy = vq[i].rdy;
      @(negedge clock);
      check($sformatf("vec%0d_req", i), 32'(m_req), 32'(vq[i].e_req));
      check($sformatf("vec%0d_addr", i), 32'(m_addr), 32'(vq[i].e_addr));
      check($sformatf("vec%0d_valid", i), 32'(m_valid), 32'(vq[i].e_valid));
      if (vq[i].e_valid || vq[i].rst) begin
        check($sformatf("vec%0d_pc", i), 32'(m_pc), 32'(vq[i].e_pc));
        check($sformatf("vec%0d_data", i), m_data, vq[i].e_data);
      end
    end

    // Random ready/redirect against the reference model
    repeat (2) begin
      @(posedge clock); #1;
      m_rst = 1'b1; m_rv = 1'b0; m_rdy = 1'b1;
    end
    exp_q.delete();
    mpc = 16'h0; ppc = 16'h0; pv = 1'b0;
    for (int k = 0; k < 10000; k++) begin
      @(posedge clock); #1;
      m_rst = 1'b0;
      m_rv  = ($urandom_range(0, 11) == 0);
      m_rpc = 16'($urandom_range(0, 16'hFFFF)) & 16'hFFFC;
      m_rdy = ($urandom_range(0, 3) != 0);
      @(negedge clock);
      ereq = !m_rv && ((exp_q.size() + (pv ? 1 : 0)) < 4);
      check("rnd_req", 32'(m_req), 32'(ereq));
      if (ereq) check("rnd_addr", 32'(m_addr), 32'(mpc));
      ev = (exp_q.size() != 0);
      check("rnd_valid", 32'(m_valid), 32'(ev));
      if (ev) begin
        check("rnd_pc", 32'(m_pc), 32'(exp_q[0][47:32]));
        check("rnd_data", m_data, exp_q[0][31:0]);
      end
      if (ev && m_rdy) void'(exp_q.pop_front());
      if (pv && !m_rv) exp_q.push_back({ppc, rom(ppc)});
      pv  = ereq;
      ppc = mpc;
      if (ereq) mpc = mpc + 16'd4;
      if (m_rv) begin
        exp_q.delete();
        pv  = 1'b0;
        mpc = m_rpc;
      end
    end
    @(posedge clock); #1;
    m_rv = 1'b0; m_rdy = 1'b1;

    // Latency 3, decode stalled: credit stops at 4 requests
    repeat (2) begin
      @(posedge clock); #1;
      t_rst = 1'b1; t_rdy = 1'b0; t_rv = 1'b0;
    end
    @(posedge clock); #1;
    t_rst = 1'b0;
    nreq = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      if (t_req) begin
        check("l3_req_addr", 32'(t_addr), 32'(4 * nreq));
        nreq++;
      end
      @(posedge clock); #1;
    end
    check("l3_req_count", 32'(nreq), 32'd4);
    @(negedge clock);
    check("l3_stall_req", 32'(t_req), 32'd0);
    check("l3_stall_valid", 32'(t_valid), 32'd1);
    check("l3_stall_pc", 32'(t_pc), 32'd0);
    @(posedge clock); #1;
    t_rdy = 1'b1;
    exp_q.delete();
    for (int k = 0; k < 5; k++) exp_q.push_back({16'(4 * k), rom(16'(4 * k))});
    for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
      @(negedge clock);
      if (t_valid && t_rdy) begin
        e = exp_q.pop_front();
        check("l3_drain_pc", 32'(t_pc), 32'(e[47:32]));
        check("l3_drain_data", t_data, e[31:0]);
      end
      @(posedge clock); #1;
    end
    check("l3_drain_left", 32'(exp_q.size()), 32'd0);

    // Latency 3 redirect: squashed responses never surface, first word at R+5
    t_rv = 1'b1; t_rpc = 16'h0100;
    @(posedge clock); #1;
    t_rv = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clock);
      if (c == 1) begin
        check("l3_redir_req", 32'(t_req), 32'd1);
        check("l3_redir_addr", 32'(t_addr), 32'h0100);
      end
      if (c < 5) begin
        check($sformatf("l3_redir_empty%0d", c), 32'(t_valid), 32'd0);
      end else begin
        check("l3_redir_valid", 32'(t_valid), 32'd1);
        check("l3_redir_pc0", 32'(t_pc), 32'h0100);
        check("l3_redir_data0", t_data, rom(16'h0100));
      end
      @(posedge clock); #1;
    end
    @(negedge clock);
    check("l3_redir_valid1", 32'(t_valid), 32'd1);
    check("l3_redir_pc1", 32'(t_pc), 32'h0104);

    // PC wrap from a start address near the top of the space
    repeat (2) begin
      @(posedge clock); #1;
      w_rst = 1'b1; w_rdy = 1'b1;
    end
    @(posedge clock); #1;
    w_rst = 1'b0;
    exp_q.delete();
    exp_q.push_back({16'hFFF8, rom(16'hFFF8)});
    exp_q.push_back({16'hFFFC, rom(16'hFFFC)});
    exp_q.push_back({16'h0000, rom(16'h0000)});
    exp_q.push_back({16'h0004, rom(16'h0004)});
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      @(negedge clock);
      if (w_valid && w_rdy) begin
        e = exp_q.pop_front();
        check("wrap_pc", 32'(w_pc), 32'(e[47:32]));
        check("wrap_data", w_data, e[31:0]);
      end
      @(posedge clock); #1;
    end
    check("wrap_left", 32'(exp_q.size()), 32'd0);

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/embark_ifetch.md
EMBARK_IFETCH -- requirements
Module: embark_ifetch

Interface
REQ-001 The module SHALL have parameter MEM_DEPTH, default 16, giving the byte-address width of the fetch PC and imem_addr.
REQ-002 The module SHALL have parameter PC_START_ADDR, default 16'h0, giving the fetch PC after reset.
REQ-003 The module SHALL have parameter FIFO_DEPTH, default 4, giving prefetch buffer entries (power of 2, >= MEM_LATENCY+1).
REQ-004 The module SHALL have parameter MEM_LATENCY, default 1, giving fixed cycles from imem_req to imem_rdata (legal range 1..4).
REQ-005 The module SHALL have port clock, input, 1, sole clock, rising edge.
REQ-006 The module SHALL have port reset, input, 1, synchronous active-high reset.
REQ-007 The module SHALL have port imem_req, output, 1, fetch request strobe.
REQ-008 The module SHALL have port imem_addr, output, MEM_DEPTH, byte address of the request.
REQ-009 The module SHALL have port imem_rdata, input, 32, instruction word, valid exactly MEM_LATENCY cycles after its request; memory never stalls.
REQ-010 The module SHALL have port redirect_valid, input, 1, branch/jump redirect strobe.
REQ-011 The module SHALL have port redirect_pc, input, MEM_DEPTH, redirect target.
REQ-012 The module SHALL have port inst_valid, output, 1, instruction available to decode.
REQ-013 The module SHALL have port inst_ready, input, 1, decode accepts.
REQ-014 The module SHALL have port inst_data, output, 32, instruction word at FIFO head.
REQ-015 The module SHALL have port inst_pc, output, MEM_DEPTH, PC of inst_data.

Function
REQ-016 Fetch PC SHALL advance by 4 on each cycle imem_req=1, wrapping modulo 2^MEM_DEPTH; imem_addr SHALL equal fetch PC.
REQ-017 imem_req SHALL be 1 iff redirect_valid=0 and (registered FIFO count + in-flight requests) < FIFO_DEPTH; credit check SHALL use registered state only (no inst_ready->imem_req path).
REQ-018 In-flight tracking SHALL be a MEM_LATENCY-stage valid/PC shift pipeline; a stage exiting valid SHALL push {imem_rdata, PC} into the FIFO that cycle.
REQ-019 The FIFO SHALL never overflow; a push when full is a design error and SHALL be flagged by assertion.
REQ-020 inst_valid SHALL equal FIFO non-empty; inst_data/inst_pc SHALL show head entry; pop on inst_valid & inst_ready.
REQ-021 Simultaneous push and pop SHALL be supported in the same cycle, including when FIFO is full (pop) or empty (push only; no bypass, data visible next cycle).
REQ-022 Redirect cycle: handshake at FIFO head SHALL still complete; then FIFO SHALL be flushed, all in-flight stages invalidated, fetch PC loaded with redirect_pc, imem_req=0.
REQ-023 First request after redirect SHALL issue the next cycle at redirect_pc; responses of squashed requests SHALL never reach the FIFO.
REQ-024 Redirect during consecutive cycles SHALL take the latest redirect_pc.
REQ-025 Latency: request issued cycle N SHALL make inst_valid visible at cycle N+MEM_LATENCY+1 if FIFO was empty.
REQ-026 With inst_ready held 1 and FIFO_DEPTH >= MEM_LATENCY+2, throughput SHALL be one instruction per cycle steady state.
REQ-027 inst_ready=0 SHALL hold inst_valid/inst_data/inst_pc stable until accepted or redirected.

Reset
REQ-028 While reset=1: imem_req=0, inst_valid=0, FIFO count=0, all in-flight valid=0, fetch PC=PC_START_ADDR, inst_data=0, inst_pc=0.
REQ-029 Reset mid-operation SHALL discard FIFO and in-flight responses; responses arriving after reset release from pre-reset requests SHALL be ignored.
REQ-030 First request SHALL issue in the first cycle after reset deasserts, at PC_START_ADDR.

Verification
REQ-031 Defaults, ready=1, ROM word i = i: release reset -> imem_addr 0,4,8,... every cycle; inst_valid at cycle 2; inst_pc 0,4,8 with data 0,1,2 back-to-back.
REQ-032 MEM_LATENCY=3, FIFO_DEPTH=4, ready=0: exactly 4 requests issued, imem_req then 0; inst_pc=0 held; set ready=1 -> PCs 0,4,8,12,16 in order, no gaps lost.
REQ-033 Redirect to 16'h0100 while 3 in flight and FIFO holding 2: no stale PC ever on inst_pc; next inst_pc = 0x0100, then 0x0104.
REQ-034 PC_START_ADDR=16'hFFF8: inst_pc sequence FFF8, FFFC, 0000, 0004.
REQ-035 Redirect with valid&ready at head pc 0x20: 0x20 consumed once; following inst_pc = redirect_pc.
REQ-036 Random ready/redirect, 10k cycles vs reference model: FIFO never overflows, in-order, correct PC/data pairing.
